// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the multiplexed 7-segment scanner.
package seg_pkg;
   localparam int RESULT_WIDTH_DEF = 7;
   localparam int NUM_DIGITS = 3;
   typedef enum logic [1:0] {DIG_OPA = 2'd0, DIG_OPB = 2'd1, DIG_SUM = 2'd2} dig_t;
   typedef enum logic {ST_BLANK, ST_DRIVE} slot_st_t;
   localparam logic [RESULT_WIDTH_DEF-1:0] SEG_OFF = '0;
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: per-slot prescaler and digit index counter for the scanner.
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int DIV = 50000,
   localparam int CW = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output dig_t          idx,
   output logic          slot_wrap,
   output logic          frame_tick
);
   assign slot_wrap  = cnt == CW'(DIV - 1);
   assign frame_tick = cnt == '0 && idx == DIG_OPA;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= DIG_OPA;
      end else if (slot_wrap) begin
         cnt <= '0;
         idx <= idx == DIG_SUM ? DIG_OPA : dig_t'(idx + 2'd1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: scans three snapshotted segment codes onto one shared bus with
// per-digit enables and leading blank cycles in every slot to avoid ghosting.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int RESULT_WIDTH   = RESULT_WIDTH_DEF,
   parameter int DIV            = 50000,
   parameter int BLANK          = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [RESULT_WIDTH-1:0] opa7seg,
   input  logic [RESULT_WIDTH-1:0] opb7seg,
   input  logic [RESULT_WIDTH-1:0] sum7seg,
   output logic [RESULT_WIDTH-1:0] seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_start
);
   localparam int CW = $clog2(DIV);
   localparam logic [RESULT_WIDTH-1:0] SEG_IDLE =
      SEG_ACTIVE_LOW ? ~RESULT_WIDTH'(SEG_OFF) : RESULT_WIDTH'(SEG_OFF);
   localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? '1 : '0;

   logic [CW-1:0]           cnt;
   dig_t                    idx;
   logic                    slot_wrap, frame_tick;
   slot_st_t                st, st_n;
   logic [RESULT_WIDTH-1:0] snap [NUM_DIGITS];
   logic [RESULT_WIDTH-1:0] lit, seg_d;
   logic [NUM_DIGITS-1:0]   en, an_d;

   seg_scan_timer #(.DIV(DIV)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt),
      .idx       (idx),
      .slot_wrap (slot_wrap),
      .frame_tick(frame_tick)
   );

   // state mirrors cnt >= BLANK, so it flips on the edge that moves cnt to BLANK
   always_ff @(posedge clk) begin
      if (rst) st <= ST_BLANK;
      else     st <= st_n;
   end

   always_comb begin
      st_n  = slot_wrap ? ST_BLANK : (cnt == CW'(BLANK - 1) ? ST_DRIVE : st);
      lit   = st == ST_DRIVE ? snap[idx] : RESULT_WIDTH'(SEG_OFF);
      en    = {NUM_DIGITS{st == ST_DRIVE}} & (NUM_DIGITS'(1) << idx);
      seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
      an_d  = AN_ACTIVE_LOW ? ~en : en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap        <= '{default: '0};
         seg_out     <= SEG_IDLE;
         an_out      <= AN_IDLE;
         frame_start <= 1'b0;
      end else begin
         if (frame_tick) snap <= '{opa7seg, opb7seg, sum7seg};
         seg_out     <= seg_d;
         an_out      <= an_d;
         frame_start <= frame_tick;
      end
   end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed and randomized checks of the scanner against a
// cycle-count reference model, for both output polarities.
module tb_seg_scan_mux;
   localparam int DIV = 8;
   localparam int BLANK = 2;
   localparam int FR = 3 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opa = 7'h06, opb = 7'h5B, sum = 7'h4F;
   logic [6:0] seg_l, seg_h;
   logic [2:0] an_l, an_h;
   logic       fs_l, fs_h;
   int         pass_cnt = 0, total = 0;

   always #5 clk = ~clk;

   seg_scan_mux #(.RESULT_WIDTH(7), .DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .opa7seg(opa), .opb7seg(opb), .sum7seg(sum),
      .seg_out(seg_l), .an_out(an_l), .frame_start(fs_l));

   seg_scan_mux #(.RESULT_WIDTH(7), .DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst(rst), .opa7seg(opa), .opb7seg(opb), .sum7seg(sum),
      .seg_out(seg_h), .an_out(an_h), .frame_start(fs_h));

   // reference: everything derives from the number of edges since reset release
   int         t = 0;
   int         m_dig = -1;
   logic       m_fs = 1'b0;
   logic [6:0] m_snap [3] = '{default: 7'h00};

   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         m_dig = -1;
         m_fs = 1'b0;
         m_snap = '{default: 7'h00};
      end else begin
         if (t % FR == 0) m_snap = '{opa, opb, sum};
         m_fs = (t % FR == 0);
         m_dig = (t % DIV < BLANK) ? -1 : (t / DIV) % 3;
         t++;
      end
   end

   function automatic logic [6:0] exp_seg(input bit low);
      logic [6:0] raw = (m_dig < 0) ? 7'h00 : m_snap[m_dig];
      return low ? ~raw : raw;
   endfunction

   function automatic logic [2:0] exp_an(input bit low);
      logic [2:0] oh = (m_dig < 0) ? 3'b000 : 3'(1 << m_dig);
      return low ? ~oh : oh;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (an_l !== 3'b111) $display("FAIL reset_an_l got %b want 111", an_l); else pass_cnt++;
      total++; if (seg_l !== 7'h7F) $display("FAIL reset_seg_l got %h want 7f", seg_l); else pass_cnt++;
      total++; if (fs_l !== 1'b0) $display("FAIL reset_fs got %b want 0", fs_l); else pass_cnt++;
      total++; if (an_h !== 3'b000) $display("FAIL reset_an_h got %b want 000", an_h); else pass_cnt++;
      total++; if (seg_h !== 7'h00) $display("FAIL reset_seg_h got %h want 00", seg_h); else pass_cnt++;
   endtask

   task automatic test_full_scan();
      logic [6:0] seg_tab [3] = '{7'h79, 7'h24, 7'h30};
      logic [2:0] an_tab [3] = '{3'b110, 3'b101, 3'b011};
      int d;
      opa = 7'h06; opb = 7'h5B; sum = 7'h4F;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= FR; k++) begin
         @(negedge clk);
         d = (k % DIV < BLANK) ? -1 : (k / DIV) % 3;
         total++; if (fs_l !== (k % FR == 0)) $display("FAIL scan_fs E0+%0d got %b", k, fs_l); else pass_cnt++;
         total++; if (an_l !== (d < 0 ? 3'b111 : an_tab[d])) $display("FAIL scan_an E0+%0d got %b", k, an_l); else pass_cnt++;
         total++; if (seg_l !== (d < 0 ? 7'h7F : seg_tab[d])) $display("FAIL scan_seg E0+%0d got %h", k, seg_l); else pass_cnt++;
      end
   endtask

   task automatic test_mid_frame();
      opa = 7'h06; opb = 7'h5B; sum = 7'h4F;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 2 * FR; k++) begin
         @(negedge clk);
         if (k == 4) sum = 7'h7D;
         if (k >= 18 && k <= 23) begin
            total++; if (seg_l !== 7'h30 || an_l !== 3'b011) $display("FAIL mid_old E0+%0d got %h/%b want 30/011", k, seg_l, an_l); else pass_cnt++;
         end
         if (k >= 42) begin
            total++; if (seg_l !== 7'h02 || an_l !== 3'b011) $display("FAIL mid_new E0+%0d got %h/%b want 02/011", k, seg_l, an_l); else pass_cnt++;
         end
      end
      sum = 7'h4F;
   endtask

   task automatic test_reset_mid_frame();
      opa = 7'h06; opb = 7'h5B; sum = 7'h4F;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 13; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (an_l !== 3'b111 || seg_l !== 7'h7F || fs_l !== 1'b0) $display("FAIL rstmid_off got %b/%h/%b", an_l, seg_l, fs_l); else pass_cnt++;
      rst = 1'b0;
      for (int k = 0; k < DIV; k++) begin
         @(negedge clk);
         total++; if (fs_l !== (k == 0)) $display("FAIL rstmid_fs E0+%0d got %b", k, fs_l); else pass_cnt++;
         total++; if (an_l !== (k < BLANK ? 3'b111 : 3'b110) || seg_l !== (k < BLANK ? 7'h7F : 7'h79))
            $display("FAIL rstmid_out E0+%0d got %b/%h", k, an_l, seg_l); else pass_cnt++;
      end
   endtask

   task automatic test_polarity();
      opa = 7'h06;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < DIV; k++) begin
         @(negedge clk);
         total++; if (an_h !== (k < BLANK ? 3'b000 : 3'b001)) $display("FAIL pol_an E0+%0d got %b", k, an_h); else pass_cnt++;
         total++; if (seg_h !== (k < BLANK ? 7'h00 : 7'h06)) $display("FAIL pol_seg E0+%0d got %h", k, seg_h); else pass_cnt++;
         total++; if (fs_h !== (k == 0)) $display("FAIL pol_fs E0+%0d got %b", k, fs_h); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 10 * FR; k++) begin
         @(negedge clk);
         total++; if (seg_l !== exp_seg(1'b1) || an_l !== exp_an(1'b1) || fs_l !== m_fs)
            $display("FAIL rand_low cyc %0d got %h/%b/%b want %h/%b/%b", k, seg_l, an_l, fs_l, exp_seg(1'b1), exp_an(1'b1), m_fs); else pass_cnt++;
         total++; if (seg_h !== exp_seg(1'b0) || an_h !== exp_an(1'b0) || fs_h !== m_fs)
            $display("FAIL rand_high cyc %0d got %h/%b/%b want %h/%b/%b", k, seg_h, an_h, fs_h, exp_seg(1'b0), exp_an(1'b0), m_fs); else pass_cnt++;
         total++; if ($countones(~an_l) > 1 || (an_l == 3'b111 && seg_l !== 7'h7F))
            $display("FAIL invariant cyc %0d got an %b seg %h", k, an_l, seg_l); else pass_cnt++;
         if ($urandom_range(4) == 0) opa = 7'($urandom);
         if ($urandom_range(4) == 0) opb = 7'($urandom);
         if ($urandom_range(4) == 0) sum = 7'($urandom);
         rst = ($urandom_range(150) == 0);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_mid_frame();
      test_reset_mid_frame();
      test_polarity();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
